// File: rtl/fsm_dispatch.sv
// Instruction dispatch controller: fetches a word, classifies its opcode and
// starts one execution sub-FSM, then waits for its completion or traps.
module fsm_dispatch #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        run,
  input  logic [31:0] ins_in,
  input  logic        mem_ready,
  input  logic        done_alu,
  input  logic        done_mem,
  input  logic        done_branch,
  input  logic        done_fpu,
  input  logic        trap_clr,
  output logic        fetch_req,
  output logic [31:0] ins,
  output logic [31:0] code,
  output logic        start_alu,
  output logic        start_mem,
  output logic        start_branch,
  output logic        start_fpu,
  output logic        busy,
  output logic        illegal,
  output logic        timeout,
  output logic [15:0] retired
);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_DISPATCH, S_WAIT, S_TRAP} state_e;
  typedef enum logic [1:0] {C_ALU, C_MEM, C_BR, C_FPU} cls_e;

  localparam logic [7:0] CNT_MAX = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  cls_e        cls_q, cls_d, dec_cls;
  logic [31:0] ins_q, ins_d, code_q, code_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [15:0] ret_d;
  logic [15:0] retired_q;
  logic        ill_q, ill_d, tmo_q, tmo_d;
  logic        dec_legal, done_sel;

  // Opcode classification works on ins[6:2] once ins[1:0] is known to be 2'b11.
  always_comb begin
    dec_legal = 1'b1;
    dec_cls   = C_ALU;
    if (ins_q[1:0] != 2'b11) begin
      dec_legal = 1'b0;
    end else begin
      case (ins_q[6:2])
        5'b01100, 5'b00100, 5'b01110, 5'b00110, 5'b01101, 5'b00101: dec_cls = C_ALU;
        5'b00000, 5'b01000, 5'b00001, 5'b01001:                     dec_cls = C_MEM;
        5'b11000, 5'b11011, 5'b11001:                               dec_cls = C_BR;
        5'b10100, 5'b10000, 5'b10001, 5'b10010, 5'b10011:           dec_cls = C_FPU;
        default:                                                    dec_legal = 1'b0;
      endcase
    end
  end

  always_comb begin
    case (cls_q)
      C_ALU:   done_sel = done_alu;
      C_MEM:   done_sel = done_mem;
      C_BR:    done_sel = done_branch;
      default: done_sel = done_fpu;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cls_d   = cls_q;
    ins_d   = ins_q;
    code_d  = code_q;
    cnt_d   = cnt_q;
    ret_d   = retired_q;
    ill_d   = ill_q;
    tmo_d   = tmo_q;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        if (mem_ready) begin
          ins_d   = ins_in;
          code_d  = 32'd1 << ins_in[6:2];
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          cls_d   = dec_cls;
          state_d = S_DISPATCH;
        end else begin
          ill_d   = 1'b1;
          state_d = S_TRAP;
        end
      end
      S_DISPATCH: begin
        cnt_d   = 8'd0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // An accepted done on the last counted cycle still retires.
        if (done_sel) begin
          ret_d   = retired_q + 16'd1;
          state_d = run ? S_FETCH : S_IDLE;
        end else if (cnt_q == CNT_MAX) begin
          tmo_d   = 1'b1;
          state_d = S_TRAP;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_TRAP: begin
        if (trap_clr) begin
          ill_d   = 1'b0;
          tmo_d   = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cls_q     <= C_ALU;
      ins_q     <= 32'd0;
      code_q    <= 32'd0;
      cnt_q     <= 8'd0;
      retired_q <= 16'd0;
      ill_q     <= 1'b0;
      tmo_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cls_q     <= cls_d;
      ins_q     <= ins_d;
      code_q    <= code_d;
      cnt_q     <= cnt_d;
      retired_q <= ret_d;
      ill_q     <= ill_d;
      tmo_q     <= tmo_d;
    end
  end

  // Handshake outputs come straight from registered state so they never glitch.
  assign fetch_req    = (state_q == S_FETCH);
  assign busy         = (state_q != S_IDLE) && (state_q != S_TRAP);
  assign start_alu    = (state_q == S_DISPATCH) && (cls_q == C_ALU);
  assign start_mem    = (state_q == S_DISPATCH) && (cls_q == C_MEM);
  assign start_branch = (state_q == S_DISPATCH) && (cls_q == C_BR);
  assign start_fpu    = (state_q == S_DISPATCH) && (cls_q == C_FPU);
  assign ins          = ins_q;
  assign code         = code_q;
  assign retired      = retired_q;
  assign illegal      = ill_q;
  assign timeout      = tmo_q;

endmodule

// File: tb/tb_fsm_dispatch.sv
// Directed bench for fsm_dispatch: expected decode/start results are queued
// when an instruction is driven and compared when the DUT presents them.
module tb_fsm_dispatch;

  logic        clk, rst_n, run, mem_ready, trap_clr;
  logic        done_alu, done_mem, done_branch, done_fpu;
  logic [31:0] ins_in;
  logic        fetch_req, busy, illegal, timeout;
  logic        start_alu, start_mem, start_branch, start_fpu;
  logic [31:0] ins, code;
  logic [15:0] retired;
  logic [3:0]  st;

  typedef struct {
    logic [31:0] code;
    logic [3:0]  st;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_ret = 16'd0;

  fsm_dispatch #(.TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .ins_in(ins_in), .mem_ready(mem_ready),
    .done_alu(done_alu), .done_mem(done_mem), .done_branch(done_branch),
    .done_fpu(done_fpu), .trap_clr(trap_clr), .fetch_req(fetch_req), .ins(ins),
    .code(code), .start_alu(start_alu), .start_mem(start_mem),
    .start_branch(start_branch), .start_fpu(start_fpu), .busy(busy),
    .illegal(illegal), .timeout(timeout), .retired(retired)
  );

  assign st = {start_fpu, start_branch, start_mem, start_alu};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_done(input logic [3:0] v);
    {done_fpu, done_branch, done_mem, done_alu} = v;
  endtask

  task automatic wait_fetch();
    int n;
    n = 0;
    while (!fetch_req && n < 20) begin
      tick();
      n++;
    end
    chk("fetch_req", 32'(fetch_req), 32'd1);
  endtask

  // noise: non-selected done lines pulsed on the first WAIT cycle.
  // dly: cycles from the start pulse to the selected done (>= 2).
  task automatic run_ins(input logic [31:0] iw, input logic [3:0] st_exp,
                         input logic [31:0] c_exp, input int dly,
                         input logic [3:0] noise, input bit stop);
    exp_t e;
    wait_fetch();
    ins_in    = iw;
    mem_ready = 1'b1;
    sbq.push_back('{code: c_exp, st: st_exp});
    tick();
    mem_ready = 1'b0;
    e = sbq.pop_front();
    chk("code", code, e.code);
    chk("ins", ins, iw);
    chk("start_in_decode", 32'(st), 32'd0);
    tick();
    chk("start", 32'(st), 32'(e.st));
    chk("busy_dispatch", 32'(busy), 32'd1);
    if (stop) run = 1'b0;
    tick();
    chk("start_one_cycle", 32'(st), 32'd0);
    set_done(noise);
    tick();
    set_done(4'd0);
    for (int k = 2; k < dly; k++) tick();
    chk("retired_before_done", 32'(retired), 32'(exp_ret));
    set_done(e.st);
    tick();
    set_done(4'd0);
    exp_ret = exp_ret + 16'd1;
    chk("retired", 32'(retired), 32'(exp_ret));
    chk("next_fetch", 32'(fetch_req), 32'(!stop));
    chk("no_timeout", 32'(timeout), 32'd0);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_fetch_req", 32'(fetch_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_start", 32'(st), 32'd0);
    chk("rst_ins", ins, 32'd0);
    chk("rst_code", code, 32'd0);
    chk("rst_retired", 32'(retired), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; run = 1'b0; mem_ready = 1'b0; trap_clr = 1'b0;
    ins_in = 32'd0; set_done(4'd0);
    #12;
    chk_reset_outputs();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // add, then back-to-back addi/srai with run held
    run = 1'b1;
    tick();
    run_ins(32'h001102B3, 4'b0001, 32'h00001000, 2, 4'b0000, 1'b0);
    run_ins(32'h00A08313, 4'b0001, 32'h00000010, 2, 4'b0000, 1'b0);
    run_ins(32'h405A5513, 4'b0001, 32'h00000010, 2, 4'b0000, 1'b0);
    // branch and fpu with foreign done pulses; run dropped mid-instruction
    run_ins(32'h00208463, 4'b0100, 32'h01000000, 3, 4'b0001, 1'b0);
    run_ins(32'h00208053, 4'b1000, 32'h00100000, 4, 4'b0110, 1'b1);
    tick();
    chk("idle_after_stop", 32'(busy), 32'd0);

    // illegal opcode
    run = 1'b1;
    wait_fetch();
    ins_in = 32'h00000000; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("ill_code", code, 32'd1);
    tick();
    chk("ill_flag", 32'(illegal), 32'd1);
    chk("ill_start", 32'(st), 32'd0);
    chk("ill_busy", 32'(busy), 32'd0);
    tick();
    chk("ill_sticky", 32'(illegal), 32'd1);
    chk("trap_fetch_req", 32'(fetch_req), 32'd0);
    trap_clr = 1'b1;
    tick();
    trap_clr = 1'b0;
    chk("ill_cleared", 32'(illegal), 32'd0);
    chk("ill_idle", 32'(busy), 32'd0);

    // timeout: lw, done_mem never comes, done_alu and trap_clr ignored in WAIT
    wait_fetch();
    ins_in = 32'h0000A283; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("lw_code", code, 32'd1);
    tick();
    chk("lw_start", 32'(st), 32'b0010);
    tick();
    for (int k = 0; k < 64; k++) begin
      if (k == 63) begin
        chk("tmo_not_yet", 32'(timeout), 32'd0);
        chk("tmo_busy", 32'(busy), 32'd1);
      end
      done_alu = (k == 5);
      trap_clr = (k == 10);
      tick();
    end
    done_alu = 1'b0; trap_clr = 1'b0;
    chk("tmo_flag", 32'(timeout), 32'd1);
    chk("tmo_busy_trap", 32'(busy), 32'd0);
    chk("tmo_retired", 32'(retired), 32'(exp_ret));
    tick();
    chk("tmo_sticky", 32'(timeout), 32'd1);
    trap_clr = 1'b1;
    tick();
    trap_clr = 1'b0;
    chk("tmo_cleared", 32'(timeout), 32'd0);

    // done on the last counted WAIT cycle wins over the timeout
    run_ins(32'h0000A283, 4'b0010, 32'h00000001, 64, 4'b0001, 1'b0);

    // retired wrap
    force dut.retired_q = 16'hFFFF;
    #1;
    release dut.retired_q;
    exp_ret = 16'hFFFF;
    chk("preload", 32'(retired), 32'h0000FFFF);
    run_ins(32'h001102B3, 4'b0001, 32'h00001000, 2, 4'b0000, 1'b0);
    run_ins(32'h001102B3, 4'b0001, 32'h00001000, 2, 4'b0000, 1'b0);

    // asynchronous reset in the middle of WAIT
    wait_fetch();
    ins_in = 32'h00208463; mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    tick();
    tick();
    chk("mid_wait_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset_outputs();
    run = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_retired", 32'(retired), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
